// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO-fed byte FIFO draining into an 8N1, LSB-first serial transmitter.
// Back-to-back frames chain straight from STOP into START when the FIFO still holds data.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          Rst,
    input  logic                          mmio_wea,
    input  logic [31:0]                   mmio_dat,
    output logic                          mmio_read,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, ovf_q, ovf_d;
    logic          full, empty, push, pop, last;
    logic          unused_hi;

    assign unused_hi = ^mmio_dat[31:8];
    // Fullness uses the pre-edge count, so a same-cycle pop never makes room.
    assign full  = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty = count_q == '0;
    assign push  = mmio_wea && !full;
    assign last  = cnt_q == CW'(CLKS_PER_BIT - 1);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
        ovf_d    = (mmio_wea && full) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= mmio_dat[7:0];
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx         = tx_q;
    assign tx_done    = state_q == STOP && last;
    assign tx_busy    = state_q != IDLE || !empty;
    assign mmio_read  = !full;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule
